snake_engine: RTL and testbench
===============================

Name: snake_engine

Overview:
- Game-logic controller for the snake datapath: owns the snake segment position array, current length, food position, direction and game state.
- Advances the snake one cell per move strobe, detects wall and self collisions, grows on food, and places new food from an external random source.
- Outputs drive the grid-rendering converter directly: `pos`, `length`, `foodPos`.
- Position encoding is one byte: {row[3:0], col[3:0]}, so row = pos>>4 and col = pos%16 on a 16x16 grid.

Parameters:
- MAX_LEN, 8, maximum snake length in segments (renderer draws indices 0..7).
- INIT_LEN, 3, length loaded on start.
- START_POS, 8'h88, head position loaded on start. Body extends leftwards: START_POS-i for i < INIT_LEN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a new game from IDLE or OVER.
- tick  in  1  single-cycle move strobe from the game-speed divider.
- dir  in  2  requested direction: 0 up (row-1), 1 right (col+1), 2 down (row+1), 3 left (col-1).
- rnd  in  8  free-running pseudo-random value (LFSR), sampled for food placement.
- pos  out  256x8  segment positions; index 0 is the head. Indices >= length read 0.
- length  out  8  current snake length.
- foodPos  out  8  current food position.
- score  out  8  foods eaten this game; wraps 255->0.
- game_over  out  1  high while in OVER.

Behaviour:
- Reset (async, reset_n low): state=IDLE, all pos=0, length=0, foodPos=0, score=0, game_over=0, cur_dir=1 (right). Takes effect immediately, including mid-move or mid-food-search.
- States: IDLE, FOOD, RUN, OVER.
- IDLE / OVER, start=1 (next edge):
  - load pos[i]=START_POS-i for i<INIT_LEN, all other entries 0;
  - length=INIT_LEN, score=0, cur_dir=1, game_over=0;
  - go to FOOD.
  - tick is ignored in IDLE and OVER. start has priority over tick.
- FOOD:
  - Each cycle, compare rnd against pos[0..length-1].
  - No match: foodPos<=rnd, go to RUN (1 cycle latency from acceptance).
  - Match: stay in FOOD and retry next cycle.
  - tick is ignored (dropped, not queued); start is ignored.
- RUN, tick=1:
  - Direction: if dir is the reverse of cur_dir (dir == cur_dir ^ 2), keep cur_dir; otherwise cur_dir<=dir. The effective direction is used for this move.
  - Compute new head from pos[0] using the effective direction.
  - Wall collision: row or col would leave 0..15 (e.g. col 15 moving right, row 0 moving up). Then go to OVER, game_over=1, and pos, length and foodPos are frozen (no shift).
  - eat = (new head == foodPos).
  - Self collision: new head equals pos[i] for i in 0..length-2 (tail excluded, since it vacates). When eat and length<MAX_LEN, the tail is included (i up to length-1). Result is the same as a wall collision: OVER, state frozen.
  - Otherwise, in one edge: shift pos[i]<=pos[i-1] for i=1..MAX_LEN-1, pos[0]<=new head, then clear every index >= the new length.
  - eat with length<MAX_LEN: length+1 (old tail retained).
  - eat with length==MAX_LEN: length stays, tail dropped.
  - On eat: score+1, go to FOOD. On no eat: stay in RUN.
- RUN, start=1: restart exactly as from IDLE. Start wins over a simultaneous tick.
- All outputs are registered. pos, length and score update on the edge that samples tick (1-cycle latency).
- Wall and self collision on the same move: single transition to OVER.

Test Plan:
- Reset, then start -> one cycle later pos[0..2]=88,87,86, length=3, state FOOD.
  - Then rnd=87 for 1 cycle, then rnd=8A -> foodPos stays 0 during the retry, becomes 8A on the following edge; state RUN.
- From that state, dir=1, tick -> pos=89,88,87, length=3, score=0.
  - Second tick -> pos=8A,89,88,87, length=4, score=1, state FOOD; a tick pulsed while in FOOD leaves pos unchanged.
- Reversal: moving right with head 8A, dir=3, tick -> head 8B (reversal ignored).
  - Then dir=0, tick -> head 7B.
- Wall: head 8F moving right, tick -> game_over=1 next edge, pos/length unchanged.
  - Further ticks have no effect; start -> fresh game, game_over=0, score=0.
- Self collision: length 5 body 55,56,66,65,64, tail at 64; dir=2 from head 55 targets 65 -> OVER.
  - Same with body 55,56,66,65 (length 4): head 65 equals the tail, so it moves legally, giving pos 65,55,56,66.
- Full length: length=8, eat -> length stays 8, score increments, pos[8]=0.
  - Assert reset_n low during FOOD -> all outputs 0 immediately.

Source files
------------

// File: rtl/snake_engine.sv
// snake_engine: snake game controller covering movement, wall/self collisions,
// growth on food, and food placement from an external random source.
module snake_engine #(
    parameter int         MAX_LEN   = 8,
    parameter int         INIT_LEN  = 3,
    parameter logic [7:0] START_POS = 8'h88
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               tick,
    input  logic [1:0]         dir,
    input  logic [7:0]         rnd,
    output logic [255:0][7:0]  pos,
    output logic [7:0]         length,
    output logic [7:0]         foodPos,
    output logic [7:0]         score,
    output logic               game_over
);
    typedef enum logic [1:0] {IDLE, FOOD, RUN, OVER} state_t;

    state_t                    state_q, state_d;
    logic [MAX_LEN-1:0][7:0]   pos_q, pos_d, init_pos, shift_pos;
    logic [7:0]                len_q, len_d, food_q, food_d, score_q, score_d, new_len;
    logic [1:0]                dir_q, dir_d, eff_dir;
    logic                      over_q, over_d;
    logic [3:0]                row, col;
    logic [7:0]                new_head;
    logic                      wall, eat, grow, self_hit, food_hit;

    always_comb begin
        row      = pos_q[0][7:4];
        col      = pos_q[0][3:0];
        eff_dir  = (dir == (dir_q ^ 2'd2)) ? dir_q : dir;
        wall     = (eff_dir == 2'd0 && row == 4'd0)  || (eff_dir == 2'd1 && col == 4'd15) ||
                   (eff_dir == 2'd2 && row == 4'd15) || (eff_dir == 2'd3 && col == 4'd0);
        new_head = eff_dir == 2'd0 ? {row - 4'd1, col} :
                   eff_dir == 2'd1 ? {row, col + 4'd1} :
                   eff_dir == 2'd2 ? {row + 4'd1, col} : {row, col - 4'd1};
        eat      = new_head == food_q;
        grow     = eat && len_q < 8'(MAX_LEN);
        new_len  = len_q + {7'd0, grow};
        // The tail vacates on a plain move, so it only blocks the head when growing.
        self_hit  = 1'b0;
        food_hit  = 1'b0;
        shift_pos = {pos_q[MAX_LEN-2:0], new_head};
        for (int i = 0; i < MAX_LEN; i++) begin
            if (8'(i + 1) < new_len && pos_q[i] == new_head) self_hit = 1'b1;
            if (8'(i) < len_q && pos_q[i] == rnd) food_hit = 1'b1;
            init_pos[i]  = i < INIT_LEN ? START_POS - 8'(i) : 8'd0;
            shift_pos[i] = 8'(i) < new_len ? shift_pos[i] : 8'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        len_d   = len_q;
        food_d  = food_q;
        score_d = score_q;
        dir_d   = dir_q;
        over_d  = over_q;
        if (start && state_q != FOOD) begin
            pos_d   = init_pos;
            len_d   = 8'(INIT_LEN);
            score_d = 8'd0;
            dir_d   = 2'd1;
            over_d  = 1'b0;
            state_d = FOOD;
        end else if (state_q == FOOD) begin
            if (!food_hit) begin
                food_d  = rnd;
                state_d = RUN;
            end
        end else if (state_q == RUN && tick) begin
            dir_d = eff_dir;
            if (wall || self_hit) begin
                over_d  = 1'b1;
                state_d = OVER;
            end else begin
                pos_d   = shift_pos;
                len_d   = new_len;
                score_d = eat ? score_q + 8'd1 : score_q;
                state_d = eat ? FOOD : RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pos_q   <= '0;
            len_q   <= 8'd0;
            food_q  <= 8'd0;
            score_q <= 8'd0;
            dir_q   <= 2'd1;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            len_q   <= len_d;
            food_q  <= food_d;
            score_q <= score_d;
            dir_q   <= dir_d;
            over_q  <= over_d;
        end
    end

    always_comb begin
        pos                = '0;
        pos[MAX_LEN-1:0]   = pos_q;
    end

    assign length    = len_q;
    assign foodPos   = food_q;
    assign score     = score_q;
    assign game_over = over_q;
endmodule

// File: tb/tb_snake_engine.sv
// tb_snake_engine: directed vector table for snake_engine plus hand-written
// reset and restart sequences.
module tb_snake_engine;
    logic              clk = 1'b0;
    logic              reset_n, start, tick;
    logic [1:0]        dir;
    logic [7:0]        rnd;
    logic [255:0][7:0] pos;
    logic [7:0]        length, foodPos, score;
    logic              game_over;

    snake_engine dut (
        .clk(clk), .reset_n(reset_n), .start(start), .tick(tick), .dir(dir), .rnd(rnd),
        .pos(pos), .length(length), .foodPos(foodPos), .score(score), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s, t;
        logic [1:0]  d;
        logic [7:0]  r;
        logic [63:0] p;
        logic [7:0]  l, f, c;
        logic        o;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;

    function automatic void add(input logic s, input logic t, input logic [1:0] d, input logic [7:0] r,
                                input logic [63:0] p, input logic [7:0] l, input logic [7:0] f,
                                input logic [7:0] c, input logic o);
        vec_t v;
        v.s = s; v.t = t; v.d = d; v.r = r; v.p = p; v.l = l; v.f = f; v.c = c; v.o = o;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] p, input logic [7:0] l,
                         input logic [7:0] f, input logic [7:0] c, input logic o);
        logic [63:0] got_p;
        got_p = '0;
        for (int k = 0; k < 8; k++) got_p = {got_p[55:0], pos[k]};
        total++;
        if ({got_p, length, foodPos, score, game_over} === {p, l, f, c, o} && pos[255:8] === '0)
            passed++;
        else
            $display("FAIL %s: got pos=%h hi_zero=%0b len=%0d food=%h score=%0d over=%0b, want pos=%h len=%0d food=%h score=%0d over=%0b",
                     name, got_p, pos[255:8] === '0, length, foodPos, score, game_over, p, l, f, c, o);
    endtask

    initial begin
        // start/food retry/first moves
        add(1, 0, 0, 8'h87, 64'h8887860000000000, 3, 8'h00, 0, 0);
        add(0, 0, 0, 8'h87, 64'h8887860000000000, 3, 8'h00, 0, 0);
        add(0, 0, 0, 8'h8A, 64'h8887860000000000, 3, 8'h8A, 0, 0);
        add(0, 1, 1, 8'h00, 64'h8988870000000000, 3, 8'h8A, 0, 0);
        add(0, 1, 1, 8'h00, 64'h8A89888700000000, 4, 8'h8A, 1, 0);
        add(0, 1, 1, 8'h8A, 64'h8A89888700000000, 4, 8'h8A, 1, 0);
        add(0, 0, 0, 8'h8B, 64'h8A89888700000000, 4, 8'h8B, 1, 0);
        // reversal ignored, then turn up
        add(0, 1, 3, 8'h00, 64'h8B8A898887000000, 5, 8'h8B, 2, 0);
        add(0, 0, 0, 8'h7B, 64'h8B8A898887000000, 5, 8'h7B, 2, 0);
        add(0, 1, 0, 8'h00, 64'h7B8B8A8988870000, 6, 8'h7B, 3, 0);
        add(0, 0, 0, 8'h00, 64'h7B8B8A8988870000, 6, 8'h00, 3, 0);
        add(0, 1, 3, 8'h00, 64'h7A7B8B8A89880000, 6, 8'h00, 3, 0);
        // self collision, then frozen
        add(0, 1, 2, 8'h00, 64'h7A7B8B8A89880000, 6, 8'h00, 3, 1);
        add(0, 1, 1, 8'h00, 64'h7A7B8B8A89880000, 6, 8'h00, 3, 1);
        add(1, 0, 0, 8'h00, 64'h8887860000000000, 3, 8'h00, 0, 0);
        add(0, 0, 0, 8'h98, 64'h8887860000000000, 3, 8'h98, 0, 0);
        add(0, 1, 2, 8'h00, 64'h9888878600000000, 4, 8'h98, 1, 0);
        add(0, 0, 0, 8'h89, 64'h9888878600000000, 4, 8'h89, 1, 0);
        add(0, 1, 3, 8'h00, 64'h9798888700000000, 4, 8'h89, 1, 0);
        // head steps into the vacating tail cell
        add(0, 1, 0, 8'h00, 64'h8797988800000000, 4, 8'h89, 1, 0);
        add(0, 1, 1, 8'h00, 64'h8887979800000000, 4, 8'h89, 1, 0);
        add(0, 1, 1, 8'h00, 64'h8988879798000000, 5, 8'h89, 2, 0);
        add(0, 0, 0, 8'h8A, 64'h8988879798000000, 5, 8'h8A, 2, 0);
        add(0, 1, 1, 8'h00, 64'h8A89888797980000, 6, 8'h8A, 3, 0);
        add(0, 0, 0, 8'h8B, 64'h8A89888797980000, 6, 8'h8B, 3, 0);
        add(0, 1, 1, 8'h00, 64'h8B8A898887979800, 7, 8'h8B, 4, 0);
        add(0, 0, 0, 8'h8C, 64'h8B8A898887979800, 7, 8'h8C, 4, 0);
        add(0, 1, 1, 8'h00, 64'h8C8B8A8988879798, 8, 8'h8C, 5, 0);
        add(0, 0, 0, 8'h8D, 64'h8C8B8A8988879798, 8, 8'h8D, 5, 0);
        // eating at full length drops the tail
        add(0, 1, 1, 8'h00, 64'h8D8C8B8A89888797, 8, 8'h8D, 6, 0);
        add(0, 0, 0, 8'h8E, 64'h8D8C8B8A89888797, 8, 8'h8E, 6, 0);
        add(0, 1, 1, 8'h00, 64'h8E8D8C8B8A898887, 8, 8'h8E, 7, 0);
        add(0, 0, 0, 8'h8F, 64'h8E8D8C8B8A898887, 8, 8'h8F, 7, 0);
        add(0, 1, 1, 8'h00, 64'h8F8E8D8C8B8A8988, 8, 8'h8F, 8, 0);
        add(0, 0, 0, 8'h00, 64'h8F8E8D8C8B8A8988, 8, 8'h00, 8, 0);
        // right wall, then frozen, then restart
        add(0, 1, 1, 8'h00, 64'h8F8E8D8C8B8A8988, 8, 8'h00, 8, 1);
        add(0, 1, 1, 8'h00, 64'h8F8E8D8C8B8A8988, 8, 8'h00, 8, 1);
        add(1, 0, 0, 8'h00, 64'h8887860000000000, 3, 8'h00, 0, 0);
        add(0, 0, 0, 8'h20, 64'h8887860000000000, 3, 8'h20, 0, 0);
        // start beats a simultaneous tick in RUN
        add(1, 1, 2, 8'h00, 64'h8887860000000000, 3, 8'h20, 0, 0);
        add(0, 0, 0, 8'h88, 64'h8887860000000000, 3, 8'h20, 0, 0);

        reset_n = 1'b0; start = 1'b0; tick = 1'b0; dir = 2'd0; rnd = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 64'h0, 0, 8'h00, 0, 0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].s; tick = vecs[i].t; dir = vecs[i].d; rnd = vecs[i].r;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].p, vecs[i].l, vecs[i].f, vecs[i].c, vecs[i].o);
        end
        start = 1'b0; tick = 1'b0;

        // async reset while searching for food
        reset_n = 1'b0;
        #1;
        check("async_reset", 64'h0, 0, 8'h00, 0, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick = 1'b1; dir = 2'd1;
        @(posedge clk);
        #1;
        check("idle_tick", 64'h0, 0, 8'h00, 0, 0);
        tick = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        check("start_after_reset", 64'h8887860000000000, 3, 8'h00, 0, 0);
        start = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
